// File: rtl/instruction_memory_pipelined_if.sv
// Fetch request/response bus between an IFU (master) and instruction_memory_pipelined (slave).
// The flush signal exists only when IMEM_FLUSH_EN is defined.
interface instruction_memory_pipelined_if #(
  parameter int ADDR_W          = 32,
  parameter int FETCH_WORDS     = 1,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_W-1:0]        req_addr;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [32*FETCH_WORDS-1:0] resp_data;
  logic [ADDR_W-1:0]        resp_addr;
  logic                     resp_err;
  logic [CNT_W-1:0]         outstanding;
`ifdef IMEM_FLUSH_EN
  logic                     flush;
`endif

  modport master (
    output req_valid, req_addr, resp_ready,
`ifdef IMEM_FLUSH_EN
    output flush,
`endif
    input  req_ready, resp_valid, resp_data, resp_addr, resp_err, outstanding
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
`ifdef IMEM_FLUSH_EN
    input  flush,
`endif
    output req_ready, resp_valid, resp_data, resp_addr, resp_err, outstanding
  );
endinterface

// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction ROM: in-order FETCH_WORDS blocks LATENCY cycles after accept, bad addresses flagged.
// req_ready comes from the registered in-flight count only (MAX_OUTSTANDING credits); IMEM_FLUSH_EN adds flush.
module instruction_memory_pipelined #(
  parameter int    ADDR_W          = 32,
  parameter int    MEM_WORDS       = 1024,
  parameter int    FETCH_WORDS     = 1,
  parameter int    LATENCY         = 1,
  parameter int    MAX_OUTSTANDING = 4,
  parameter string INIT_FILE       = ""
) (
  input logic                           clk,
  input logic                           rst_n,
  instruction_memory_pipelined_if.slave bus
);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OFF_W   = $clog2(FETCH_WORDS);
  localparam int DATA_W  = 32 * FETCH_WORDS;
  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W + 1)'(MEM_WORDS - FETCH_WORDS);
  // Only the built-in pattern is modelled in synthesizable form; other images read as zero.
  localparam bit DEFAULT_IMAGE = (INIT_FILE == "");

  function automatic logic [31:0] rom_word(input logic [23:0] idx);
    return DEFAULT_IMAGE ? (32'h0010_0000 | {idx, 8'h00}) : 32'h0;
  endfunction

  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              pop;
  logic [LATENCY-1:0] pipe_vld;
  logic [ADDR_W-1:0] pipe_addr [LATENCY];

  logic [ADDR_W-1:0] exit_addr;
  logic [ADDR_W:0]   word_ext;
  logic              err_offset;
  logic              exit_err;
  logic [DATA_W-1:0] exit_data;

  logic [ENTRY_W-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               push;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef IMEM_FLUSH_EN
  assign bus.req_ready = (count < CNT_W'(MAX_OUTSTANDING)) && !bus.flush;
`else
  assign bus.req_ready = (count < CNT_W'(MAX_OUTSTANDING));
`endif
  assign accept          = bus.req_valid && bus.req_ready;
  assign pop             = bus.resp_valid && bus.resp_ready;
  assign bus.outstanding = count;

  // Credits cover both the delay pipe and the FIFO, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
`ifdef IMEM_FLUSH_EN
    else if (bus.flush)
      count <= '0;
`endif
    else
      count <= count + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_addr[i] <= '0;
    end
`ifdef IMEM_FLUSH_EN
    else if (bus.flush) begin
      pipe_vld <= '0;
    end
`endif
    else begin
      pipe_vld[0]  <= accept;
      pipe_addr[0] <= bus.req_addr;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign exit_addr = pipe_addr[LATENCY-1];
  assign push      = pipe_vld[LATENCY-1];
  assign word_ext  = {3'b000, exit_addr[ADDR_W-1:2]};

  generate
    if (OFF_W > 0) begin : g_off
      assign err_offset = |exit_addr[2 +: OFF_W];
    end else begin : g_no_off
      assign err_offset = 1'b0;
    end
  endgenerate

  assign exit_err = (|exit_addr[1:0]) || err_offset || (word_ext > LAST_BASE);

  always_comb begin
    exit_data = '0;
    if (!exit_err)
      for (int k = 0; k < FETCH_WORDS; k++)
        exit_data[32*k +: 32] = rom_word(24'(word_ext + (ADDR_W + 1)'(k)));
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {exit_data, exit_addr, exit_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end
`ifdef IMEM_FLUSH_EN
    else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end
`endif
    else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Head is masked while empty so idle outputs read as zero.
  assign bus.resp_valid = (fifo_cnt != '0);
  assign {bus.resp_data, bus.resp_addr, bus.resp_err} = bus.resp_valid ? fifo_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Bench: time-stamped expected-response queue model driving a LATENCY=2 instance, plus a FETCH_WORDS=2 instance.
module tb_instruction_memory_pipelined;
  localparam int MEM_WORDS = 1024;
  localparam int LAT       = 2;
  localparam int MAX_OUT   = 4;
  localparam int LAT2      = 1;
  localparam int MAX_OUT2  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_memory_pipelined_if #(.ADDR_W(32), .FETCH_WORDS(1), .MAX_OUTSTANDING(MAX_OUT))  bus  ();
  instruction_memory_pipelined_if #(.ADDR_W(32), .FETCH_WORDS(2), .MAX_OUTSTANDING(MAX_OUT2)) bus2 ();

  instruction_memory_pipelined #(.ADDR_W(32), .MEM_WORDS(MEM_WORDS), .FETCH_WORDS(1), .LATENCY(LAT),
    .MAX_OUTSTANDING(MAX_OUT), .INIT_FILE("")) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  instruction_memory_pipelined #(.ADDR_W(32), .MEM_WORDS(MEM_WORDS), .FETCH_WORDS(2), .LATENCY(LAT2),
    .MAX_OUTSTANDING(MAX_OUT2), .INIT_FILE("")) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          t;
  } ent_t;

  ent_t mq[$];
  ent_t popped[$];
  int   mcnt = 0;
  int   now = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rom(input longint i);
    return 32'(64'h0010_0000 | (i << 8));
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input int fw);
    longint idx;
    idx = longint'(a) / 4;
    return (a % 4 != 0) || (idx % fw != 0) || (idx + fw > MEM_WORDS);
  endfunction

  function automatic logic [63:0] blk2(input logic [31:0] a);
    longint idx;
    idx = longint'(a) / 4;
    return exp_err(a, 2) ? 64'h0 : {rom(idx + 1), rom(idx)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vld, input logic [31:0] addr, input logic rdy, input logic fl);
    logic ev, acc, pp, e;
    ev = (mq.size() > 0) && (mq[0].t <= now);
    check("outstanding", 64'(bus.outstanding), 64'(mcnt));
    check("req_ready", 64'(bus.req_ready), 64'(mcnt < MAX_OUT));
    check("resp_valid", 64'(bus.resp_valid), 64'(ev));
    if (ev) begin
      check("resp_data", 64'(bus.resp_data), 64'(mq[0].data));
      check("resp_addr", 64'(bus.resp_addr), 64'(mq[0].addr));
      check("resp_err", 64'(bus.resp_err), 64'(mq[0].err));
    end
    bus.req_valid  = vld;
    bus.req_addr   = addr;
    bus.resp_ready = rdy;
`ifdef IMEM_FLUSH_EN
    bus.flush = fl;
    if (fl) begin
      #1 check("flush_req_ready", 64'(bus.req_ready), 64'(0));
    end
`endif
    acc = vld && (mcnt < MAX_OUT) && !fl;
    pp  = ev && rdy && !fl;
    if (pp) begin
      popped.push_back('{addr: bus.resp_addr, data: bus.resp_data, err: bus.resp_err, t: now});
      void'(mq.pop_front());
    end
    if (fl) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (acc) begin
        e = exp_err(addr, 1);
        mq.push_back('{addr: addr, data: e ? 32'h0 : rom(longint'(addr) / 4), err: e, t: now + 1 + LAT});
      end
      mcnt = mcnt + int'(acc) - int'(pp);
    end
    @(posedge clk);
    #1;
`ifdef IMEM_FLUSH_EN
    bus.flush = 1'b0;
`endif
    @(negedge clk);
    now++;
  endtask

  task automatic do_reset();
    bus.req_valid = 0; bus.resp_ready = 0; bus2.req_valid = 0; bus2.resp_ready = 0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_data", 64'(bus.resp_data), 64'(0));
    check("rst_addr", 64'(bus.resp_addr), 64'(0));
    check("rst_err", 64'(bus.resp_err), 64'(0));
    check("rst_outstanding", 64'(bus.outstanding), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst2_valid", 64'(bus2.resp_valid), 64'(0));
    check("rst2_outstanding", 64'(bus2.outstanding), 64'(0));
    mq.delete();
    mcnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    now++;
  endtask

  task automatic fetch2(input string tag, input logic [31:0] a, input logic [63:0] exp_data, input logic exp_e);
    int waited;
    bus2.req_valid = 1; bus2.req_addr = a; bus2.resp_ready = 0;
    #1 check({tag, "_ready"}, 64'(bus2.req_ready), 64'(1));
    @(posedge clk); @(negedge clk); now++;
    bus2.req_valid = 0;
    waited = 0;
    while (bus2.resp_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); @(negedge clk); now++; waited++;
    end
    check({tag, "_latency"}, 64'(waited), 64'(LAT2));
    check({tag, "_data"}, bus2.resp_data, exp_data);
    check({tag, "_addr"}, 64'(bus2.resp_addr), 64'(a));
    check({tag, "_err"}, 64'(bus2.resp_err), 64'(exp_e));
    bus2.resp_ready = 1;
    @(posedge clk); @(negedge clk); now++;
    bus2.resp_ready = 0;
    check({tag, "_popped"}, 64'(bus2.resp_valid), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic vld, rdy, fl;
    logic [31:0] a;
    int sel;
    bus.req_valid = 0; bus.req_addr = 0; bus.resp_ready = 0;
    bus2.req_valid = 0; bus2.req_addr = 0; bus2.resp_ready = 0;
`ifdef IMEM_FLUSH_EN
    bus.flush = 0; bus2.flush = 0;
`endif
    @(negedge clk);
    do_reset();

    // Single fetch latency
    step(1, 32'h0, 1, 0);
    step(0, 32'h0, 1, 0);
    check("t1_not_yet", 64'(bus.resp_valid), 64'(0));
    step(0, 32'h0, 1, 0);
    check("t1_valid", 64'(bus.resp_valid), 64'(1));
    check("t1_data", 64'(bus.resp_data), 64'h0010_0000);
    check("t1_addr", 64'(bus.resp_addr), 64'(0));
    check("t1_err", 64'(bus.resp_err), 64'(0));
    step(0, 32'h0, 1, 0);

    // Back-to-back stream
    n0 = popped.size();
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), 1, 0);
    repeat (LAT + 2) step(0, 32'h0, 1, 0);
    check("t2_count", 64'(popped.size() - n0), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("t2_data", 64'(popped[n0+i].data), 64'(32'h0010_0000 + 32'h100 * i));
      check("t2_consecutive", 64'(popped[n0+i].t - popped[n0].t), 64'(i));
    end

    // Credit limit under backpressure
    n0 = popped.size();
    for (int i = 0; i < 6; i++) step(1, 32'(32'h100 + 4 * i), 0, 0);
    check("t3_outstanding", 64'(bus.outstanding), 64'(4));
    check("t3_req_ready", 64'(bus.req_ready), 64'(0));
    check("t3_head", 64'(bus.resp_data), 64'h0010_4000);
    step(0, 32'h0, 0, 0);
    check("t3_hold_data", 64'(bus.resp_data), 64'h0010_4000);
    check("t3_hold_addr", 64'(bus.resp_addr), 64'h100);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);
    check("t3_pops", 64'(popped.size() - n0), 64'(4));
    for (int i = 0; i < 4; i++)
      check("t3_order", 64'(popped[n0+i].data), 64'(32'h0010_4000 + 32'h100 * i));
    step(1, 32'h200, 1, 0);
    check("t3_resume", 64'(bus.outstanding), 64'(1));
    repeat (LAT + 2) step(0, 32'h0, 1, 0);

    // Error responses keep their slot
    n0 = popped.size();
    step(1, 32'h2, 1, 0);
    step(1, 32'h1000, 1, 0);
    step(1, 32'h10, 1, 0);
    step(1, 32'hFFC, 1, 0);
    repeat (LAT + 3) step(0, 32'h0, 1, 0);
    check("t4_count", 64'(popped.size() - n0), 64'(4));
    check("t4_mis_err", 64'(popped[n0].err), 64'(1));
    check("t4_mis_data", 64'(popped[n0].data), 64'(0));
    check("t4_oor_err", 64'(popped[n0+1].err), 64'(1));
    check("t4_oor_data", 64'(popped[n0+1].data), 64'(0));
    check("t4_ok_err", 64'(popped[n0+2].err), 64'(0));
    check("t4_ok_data", 64'(popped[n0+2].data), 64'h0010_0400);
    check("t4_last_data", 64'(popped[n0+3].data), 64'h0013_FF00);

    // Two-word fetch blocks
    fetch2("t5_a", 32'h8, 64'h0010_0300_0010_0200, 1'b0);
    fetch2("t5_b", 32'h4, 64'h0, 1'b1);
    fetch2("t5_last", 32'hFF8, blk2(32'hFF8), exp_err(32'hFF8, 2));
    fetch2("t5_oor", 32'h1000, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = 32'($urandom_range(0, MEM_WORDS / 2 - 1) * 8);
      fetch2("t5_rand", a, blk2(a), exp_err(a, 2));
    end

`ifdef IMEM_FLUSH_EN
    n0 = popped.size();
    step(1, 32'h100, 0, 0);
    step(1, 32'h104, 0, 0);
    step(1, 32'h108, 0, 0);
    step(1, 32'h10C, 1, 1);
    check("t6_outstanding", 64'(bus.outstanding), 64'(0));
    check("t6_valid", 64'(bus.resp_valid), 64'(0));
    repeat (4) step(0, 32'h0, 1, 0);
    check("t6_no_resp", 64'(popped.size() - n0), 64'(0));
    step(1, 32'h40, 1, 0);
    repeat (LAT + 2) step(0, 32'h0, 1, 0);
    check("t6_single", 64'(popped.size() - n0), 64'(1));
    check("t6_data", 64'(popped[n0].data), 64'h0010_1000);
`endif

    // Reset with requests in flight
    step(1, 32'h20, 0, 0);
    step(1, 32'h24, 0, 0);
    step(1, 32'h28, 0, 0);
    check("t7_outstanding", 64'(bus.outstanding), 64'(3));
    do_reset();
    n0 = popped.size();
    repeat (6) step(0, 32'h0, 1, 0);
    check("t7_no_stale", 64'(popped.size() - n0), 64'(0));

    // Randomized traffic against the model
    repeat (400) begin
      vld = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      else if (sel < 8)  a = 32'($urandom_range(0, MEM_WORDS - 1) * 4) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'((MEM_WORDS - 2 + $urandom_range(0, 3)) * 4);
      else               a = $urandom;
      fl = 1'b0;
`ifdef IMEM_FLUSH_EN
      fl = ($urandom_range(0, 39) == 0);
`endif
      step(vld, a, rdy, fl);
    end
    repeat (LAT + MAX_OUT + 2) step(0, 32'h0, 1, 0);
    check("drain_outstanding", 64'(bus.outstanding), 64'(0));
    check("drain_valid", 64'(bus.resp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
